// File: rtl/divider_ctrl_pkg.sv
// Shared definitions for the restoring radix-2 divider controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: the FSM state encoding and the datapath mux/op select encodings
// that the controller drives onto the A/Q register selects and the adder.
package divider_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Q = 3'd1,
    ST_LOAD_M = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_SUB    = 3'd5,
    ST_FIX    = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  // A data_in mux
  localparam logic A_SEL_ADDER  = 1'b0;
  localparam logic A_SEL_ZERO   = 1'b1;
  // Q data_in mux
  localparam logic Q_SEL_INBUS  = 1'b0;
  localparam logic Q_SEL_SETLSB = 1'b1;
  // shared adder operation
  localparam logic ALU_ADD      = 1'b0;
  localparam logic ALU_SUB      = 1'b1;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: counts completed shift/sub/fix rounds.
// Latency: count updates on the edge after clr/inc; last is combinational from the count.
// Backpressure: none; inc is honoured every cycle it is high, count saturates at WIDTH.
// Ports: clk, reset (sync, active-high), clr (sync clear), inc (increment enable),
//        cnt (current count), last (count == WIDTH-1, i.e. the round in progress is the final one).
module div_iter_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      // holding at WIDTH keeps the debug view meaningful if FIX were ever re-entered
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/divider_ctrl.sv
// FSM controller for an unsigned restoring radix-2 divider (A, Q, M registers, shared adder).
// Latency: done pulses 3*WIDTH+4 cycles after start is sampled; 4 cycles on divide-by-zero.
// Backpressure: start is only sampled in IDLE; start elsewhere (including DONE) is ignored.
// Ports: clk, reset (sync, active-high), start, m_zero (M==0), a_sign (A msb after trial subtract);
//        A/Q/M load and shift enables, A/Q data_in selects, alu_sub, busy, done, div0_err, iter_cnt.
module divider_ctrl
  import divider_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             m_zero,
  input  logic             a_sign,
  output logic             a_load_en,
  output logic             a_sel,
  output logic             a_shl_en,
  output logic             q_load_en,
  output logic             q_sel,
  output logic             q_shl_en,
  output logic             m_load_en,
  output logic             alu_sub,
  output logic             busy,
  output logic             done,
  output logic             div0_err,
  output logic [CNT_W-1:0] iter_cnt
);

  state_t state;
  state_t state_nxt;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  div_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (iter_cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky until the next accepted start, so software can read it after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      div0_err <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      div0_err <= 1'b0;
    end else if (state == ST_CHECK && m_zero) begin
      div0_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    a_load_en = 1'b0;
    a_sel     = A_SEL_ADDER;
    a_shl_en  = 1'b0;
    q_load_en = 1'b0;
    q_sel     = Q_SEL_INBUS;
    q_shl_en  = 1'b0;
    m_load_en = 1'b0;
    alu_sub   = ALU_ADD;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    busy      = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD_Q;
      end
      ST_LOAD_Q: begin
        // inbus carries the dividend this cycle; A is cleared alongside
        q_load_en = 1'b1;
        q_sel     = Q_SEL_INBUS;
        a_load_en = 1'b1;
        a_sel     = A_SEL_ZERO;
        state_nxt = ST_LOAD_M;
      end
      ST_LOAD_M: begin
        m_load_en = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = m_zero ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        // A:Q shift as one 2*WIDTH+1 register; Q msb feeds A lsb in the datapath
        a_shl_en  = 1'b1;
        q_shl_en  = 1'b1;
        state_nxt = ST_SUB;
      end
      ST_SUB: begin
        a_load_en = 1'b1;
        a_sel     = A_SEL_ADDER;
        alu_sub   = ALU_SUB;
        state_nxt = ST_FIX;
      end
      ST_FIX: begin
        cnt_inc = 1'b1;
        if (a_sign) begin
          // trial went negative: add M back, quotient bit stays 0 from the shift
          a_load_en = 1'b1;
          a_sel     = A_SEL_ADDER;
          alu_sub   = ALU_ADD;
        end else begin
          q_load_en = 1'b1;
          q_sel     = Q_SEL_SETLSB;
        end
        state_nxt = cnt_last ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl with a WIDTH=8 A(9)/Q(8)/M(8) restoring-divider datapath around it.
// Latency: n/a.
// Backpressure: n/a.
module tb_divider_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          m_zero;
  logic          a_sign;
  logic          a_load_en, a_sel, a_shl_en;
  logic          q_load_en, q_sel, q_shl_en;
  logic          m_load_en, alu_sub, busy, done, div0_err;
  logic [CW-1:0] iter_cnt;

  always #5 clk = ~clk;

  divider_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .m_zero    (m_zero),
    .a_sign    (a_sign),
    .a_load_en (a_load_en),
    .a_sel     (a_sel),
    .a_shl_en  (a_shl_en),
    .q_load_en (q_load_en),
    .q_sel     (q_sel),
    .q_shl_en  (q_shl_en),
    .m_load_en (m_load_en),
    .alu_sub   (alu_sub),
    .busy      (busy),
    .done      (done),
    .div0_err  (div0_err),
    .iter_cnt  (iter_cnt)
  );

  // ---------------- datapath ----------------
  logic [W:0]   a_r;
  logic [W-1:0] q_r, m_r;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] inbus;
  logic [W:0]   adder;

  assign inbus  = m_load_en ? divisor : dividend;
  assign adder  = alu_sub ? (a_r - {1'b0, m_r}) : (a_r + {1'b0, m_r});
  assign m_zero = (m_r == '0);
  assign a_sign = a_r[W];

  always @(posedge clk) begin
    if (a_load_en)     a_r <= a_sel ? '0 : adder;
    else if (a_shl_en) a_r <= {a_r[W-1:0], q_r[W-1]};
    if (q_load_en)     q_r <= q_sel ? {q_r[W-1:1], 1'b1} : inbus;
    else if (q_shl_en) q_r <= {q_r[W-2:0], 1'b0};
    if (m_load_en)     m_r <= inbus;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  a;
    logic          div0;
    logic [CW-1:0] it;
    int            lat;
    int            acc;
    bit            chk_lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc[$];
  bit   track_busy = 1'b0;
  int   busy_drops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // done monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!reset) begin
      check("invariants",
            {28'd0, (a_load_en && a_shl_en), (q_load_en && q_shl_en),
             (done && !busy), (m_load_en && q_load_en)}, 32'd0);
    end
    if (track_busy && !busy) busy_drops++;
    if (!reset && done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",  q_r, e.q);
        check("remainder", a_r[W-1:0], e.a);
        check("div0_err",  div0_err, e.div0);
        check("iter_cnt",  iter_cnt, e.it);
        if (e.chk_lat) check("latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t e;
    if (dvs == '0) begin
      e.q = dvd; e.a = '0; e.div0 = 1'b1; e.it = '0; e.lat = 4;
    end else begin
      e.q = dvd / dvs; e.a = dvd % dvs; e.div0 = 1'b0; e.it = CW'(W); e.lat = 3 * W + 4;
    end
    e.acc = 0;
    e.chk_lat = 1'b1;
    return e;
  endfunction

  // one division; optionally a stray start pulse pulse_at cycles into the run
  task automatic do_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input int pulse_at);
    exp_t e;
    int   target;
    e = model(dvd, dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    e.acc    = cyc + 1;
    sb.push_back(e);
    target = done_cnt + 1;
    tick();
    start = 1'b0;
    track_busy = 1'b1;
    busy_drops = 0;
    for (int n = 0; n < 100; n++) begin
      start = (n == pulse_at);
      tick();
      if (done_cnt >= target) break;
    end
    start = 1'b0;
    track_busy = 1'b0;
    check("op_completed", done_cnt, target);
    if (pulse_at >= 0) check("busy_never_dropped", busy_drops, 0);
    tick();
  endtask

  initial begin
    int shifts;
    int base;
    int n_dc;

    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("reset_outputs",
          {a_load_en, a_sel, a_shl_en, q_load_en, q_sel, q_shl_en,
           m_load_en, alu_sub, busy, done, div0_err}, 0);
    check("reset_iter_cnt", iter_cnt, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    do_op(8'd100, 8'd7, -1);
    do_op(8'd255, 8'd1, -1);
    do_op(8'd5,   8'd9, -1);
    do_op(8'd77,  8'd0, -1);
    tick();
    check("div0_sticky", div0_err, 1);
    do_op(8'd9,   8'd3, -1);

    // reset during the 5th SHIFT of a run that is then abandoned
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    shifts = 0;
    for (int n = 0; n < 100; n++) begin
      if (a_shl_en) shifts++;
      if (shifts == 5) break;
      tick();
    end
    check("reached_5th_shift", shifts, 5);
    reset = 1'b1;
    tick();
    check("midrun_reset_outputs",
          {a_load_en, a_sel, a_shl_en, q_load_en, q_sel, q_shl_en,
           m_load_en, alu_sub, busy, done, div0_err}, 0);
    check("midrun_reset_iter_cnt", iter_cnt, 0);
    reset = 1'b0;
    tick();
    check("idle_after_reset", busy, 0);
    do_op(8'd200, 8'd13, -1);

    // stray start pulse mid-run
    do_op(8'd5, 8'd9, 10);
    check("single_done_pulse", sb.size(), 0);

    // start held high: three back-to-back operations
    base     = done_cnt;
    dividend = 8'd100;
    divisor  = 8'd7;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e = model(8'd100, 8'd7);
      e.chk_lat = 1'b0;
      sb.push_back(e);
    end
    start = 1'b1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (done_cnt - base >= 3) break;
    end
    start = 1'b0;
    for (int n = 0; n < 40; n++) tick();
    check("b2b_done_count", done_cnt - base, 3);
    n_dc = done_cyc.size();
    if (n_dc >= 3) begin
      check("b2b_gap1", done_cyc[n_dc-2] - done_cyc[n_dc-3], 29);
      check("b2b_gap2", done_cyc[n_dc-1] - done_cyc[n_dc-2], 29);
    end else begin
      check("b2b_done_recorded", n_dc, 3);
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
